// File: rtl/axi_ring_reader.sv
// axi_ring_reader: AXI3 read-only master that streams a circular DDR buffer
// into a first-word-fall-through FIFO, one fixed-length INCR burst at a time.
//
// Handshakes: every channel transfers on a clock edge where valid and ready are
// both high. A master holds valid (and its payload) until that edge. The stream
// side is a pop strobe: a word leaves the FIFO on Oen & Ovalid.
module axi_ring_reader #(
  parameter int          DATA_W     = 32,
  parameter int          BURST_LEN  = 16,
  parameter int          FIFO_DEPTH = 64,
  parameter logic [11:0] AXI_ID     = 12'd0
) (
  input  logic                          AXI_clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic [31:0]                   base_addr,
  input  logic [31:0]                   ring_bytes,
  output logic [DATA_W-1:0]             Sout,
  output logic                          Ovalid,
  input  logic                          Oen,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          resp_err,
  output logic                          len_err,
  output logic                          underrun,
  output logic [31:0]                   AXI_araddr,
  output logic                          AXI_arvalid,
  input  logic                          AXI_arready,
  output logic [3:0]                    AXI_arlen,
  output logic [2:0]                    AXI_arsize,
  output logic [1:0]                    AXI_arburst,
  output logic [11:0]                   AXI_arid,
  output logic [3:0]                    AXI_arcache,
  output logic [1:0]                    AXI_arlock,
  output logic [2:0]                    AXI_arprot,
  output logic [3:0]                    AXI_arqos,
  input  logic [DATA_W-1:0]             AXI_rdata,
  input  logic [11:0]                   AXI_rid,
  input  logic [1:0]                    AXI_rresp,
  input  logic                          AXI_rlast,
  input  logic                          AXI_rvalid,
  output logic                          AXI_rready,
  output logic [1:0]                    fsm_state
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int BB   = BURST_LEN * DATA_W / 8;
  localparam int SIZE = $clog2(DATA_W / 8);
  localparam logic [4:0] BL_FULL = 5'(BURST_LEN);
  localparam logic [4:0] BL_LAST = 5'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              run_q;
  logic              restart_pend;
  logic [31:0]       addr;
  logic [4:0]        beat_cnt;
  logic [LW-1:0]     wr_ptr;
  logic [LW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic              flush;
  logic              space_ok;
  logic              beat;
  logic              last_beat;
  logic              push;
  logic              pop;
  logic [32:0]       addr_sum;
  logic [32:0]       ring_end;
  logic [31:0]       next_addr;
  logic              unused_rid;

  // The read ID is constant, so returned IDs carry no information here.
  assign unused_rid = ^AXI_rid;

  // Constant AR fields
  assign AXI_arlen   = 4'(BURST_LEN - 1);
  assign AXI_arsize  = 3'(SIZE);
  assign AXI_arburst = 2'b01;
  assign AXI_arid    = AXI_ID;
  assign AXI_arcache = 4'b0011;
  assign AXI_arlock  = 2'b00;
  assign AXI_arprot  = 3'b000;
  assign AXI_arqos   = 4'b0000;

  // Channel controls follow the state directly; araddr is the ring pointer,
  // which only moves in IDLE or on the final beat, so it is stable in ADDR.
  assign AXI_arvalid = (state == ADDR);
  assign AXI_rready  = (state == DATA);
  assign AXI_araddr  = addr;
  assign fsm_state   = state;

  assign flush     = (state == IDLE) && restart_pend;
  assign space_ok  = (int'(level) + BURST_LEN) <= FIFO_DEPTH;
  assign beat      = (state == DATA) && AXI_rvalid;
  assign last_beat = beat && AXI_rlast;
  // Beats past the burst length are accepted but dropped so the reservation holds.
  assign push      = beat && (beat_cnt < BL_FULL);
  assign pop       = Oen && Ovalid;

  assign addr_sum  = {1'b0, addr} + 33'(BB);
  assign ring_end  = {1'b0, base_addr} + {1'b0, ring_bytes};
  assign next_addr = (addr_sum >= ring_end) ? base_addr : addr_sum[31:0];

  assign level  = wr_ptr - rd_ptr;
  assign Ovalid = (level != '0);
  assign Sout   = Ovalid ? mem[rd_ptr[AW-1:0]] : '0;

  // State register
  always_ff @(posedge AXI_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state: a burst is issued only when a whole burst fits in the FIFO.
  // run_q is required as well so the cycle of a rising edge never issues
  // before the restart has been recorded.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (run && run_q && !restart_pend && space_ok) next_state = ADDR;
      ADDR: if (AXI_arready) next_state = DATA;
      DATA: if (last_beat) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Rising-edge detect on run; the restart waits for IDLE before taking effect
  always_ff @(posedge AXI_clk or posedge rst) begin
    if (rst) begin
      run_q        <= 1'b0;
      restart_pend <= 1'b0;
    end else begin
      run_q <= run;
      if (run && !run_q)        restart_pend <= 1'b1;
      else if (state == IDLE)   restart_pend <= 1'b0;
    end
  end

  // Ring pointer and beat counter (saturates at the burst length)
  always_ff @(posedge AXI_clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      beat_cnt <= '0;
    end else begin
      if (flush)     addr <= base_addr;
      if (last_beat) addr <= next_addr;
      if (state == ADDR && AXI_arready)  beat_cnt <= '0;
      else if (beat && beat_cnt != BL_FULL) beat_cnt <= beat_cnt + 5'd1;
    end
  end

  // Sticky error flags
  always_ff @(posedge AXI_clk or posedge rst) begin
    if (rst) begin
      resp_err <= 1'b0;
      len_err  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (beat && AXI_rresp != 2'b00) resp_err <= 1'b1;
      if (last_beat && beat_cnt != BL_LAST) len_err <= 1'b1;
      if (beat && !AXI_rlast && beat_cnt == BL_LAST) len_err <= 1'b1;
      if (Oen && !Ovalid) underrun <= 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge AXI_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= AXI_rdata;
  end

  // FIFO pointers; a flush empties the FIFO (never coincides with a push)
  always_ff @(posedge AXI_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_ring_reader.sv
// Testbench for axi_ring_reader: directed AXI slave model, FIFO scoreboard,
// table of single-burst scenarios plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_axi_ring_reader;

  localparam int DATA_W = 32;
  localparam int BL     = 16;
  localparam int DEPTH  = 64;
  localparam int LW     = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic [31:0]       base = 32'h0;
  logic [31:0]       ring = 32'h100;
  logic [DATA_W-1:0] Sout;
  logic              Ovalid;
  logic              Oen = 1'b0;
  logic [LW-1:0]     level;
  logic              resp_err, len_err, underrun;
  logic [31:0]       AXI_araddr;
  logic              AXI_arvalid;
  logic              AXI_arready;
  logic [3:0]        AXI_arlen;
  logic [2:0]        AXI_arsize;
  logic [1:0]        AXI_arburst;
  logic [11:0]       AXI_arid;
  logic [3:0]        AXI_arcache;
  logic [1:0]        AXI_arlock;
  logic [2:0]        AXI_arprot;
  logic [3:0]        AXI_arqos;
  logic [DATA_W-1:0] AXI_rdata;
  logic [11:0]       AXI_rid;
  logic [1:0]        AXI_rresp;
  logic              AXI_rlast;
  logic              AXI_rvalid;
  logic              AXI_rready;
  logic [1:0]        fsm_state;

  axi_ring_reader #(.DATA_W(DATA_W), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .AXI_ID(12'd0)) dut (
    .AXI_clk(clk), .rst(rst), .run(run), .base_addr(base), .ring_bytes(ring),
    .Sout(Sout), .Ovalid(Ovalid), .Oen(Oen), .level(level),
    .resp_err(resp_err), .len_err(len_err), .underrun(underrun),
    .AXI_araddr(AXI_araddr), .AXI_arvalid(AXI_arvalid), .AXI_arready(AXI_arready),
    .AXI_arlen(AXI_arlen), .AXI_arsize(AXI_arsize), .AXI_arburst(AXI_arburst),
    .AXI_arid(AXI_arid), .AXI_arcache(AXI_arcache), .AXI_arlock(AXI_arlock),
    .AXI_arprot(AXI_arprot), .AXI_arqos(AXI_arqos),
    .AXI_rdata(AXI_rdata), .AXI_rid(AXI_rid), .AXI_rresp(AXI_rresp),
    .AXI_rlast(AXI_rlast), .AXI_rvalid(AXI_rvalid), .AXI_rready(AXI_rready),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [31:0]       ar_q[$];
  int ar_cnt   = 0;
  int n_popped = 0;

  // slave model state and per-test configuration (applies to burst 0 only)
  int s_phase = 0, s_wait = 0, s_beat = 0, s_burst = 0;
  int cfg_ar_delay = 0, cfg_last = BL - 1, cfg_err = -1;
  logic [31:0] held_addr = 32'h0;
  logic [31:0] data_ctr  = 32'h100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    Oen = 1'b0;
    tick(3);
    exp_q.delete();
    ar_q.delete();
    ar_cnt       = 0;
    n_popped     = 0;
    cfg_ar_delay = 0;
    cfg_last     = BL - 1;
    cfg_err      = -1;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"},  AXI_arvalid, 0);
    check({tag, "_rready"},   AXI_rready,  0);
    check({tag, "_araddr"},   AXI_araddr,  0);
    check({tag, "_ovalid"},   Ovalid,      0);
    check({tag, "_level"},    level,       0);
    check({tag, "_resp_err"}, resp_err,    0);
    check({tag, "_len_err"},  len_err,     0);
    check({tag, "_underrun"}, underrun,    0);
    check({tag, "_state"},    fsm_state,   0);
  endtask

  // R beat presented by the slave; only beats within the burst length are expected to be stored
  task automatic present_beat();
    int last;
    last = (s_burst == 0) ? cfg_last : BL - 1;
    AXI_rvalid = 1'b1;
    AXI_rdata  = data_ctr;
    data_ctr   = data_ctr + 32'd1;
    AXI_rlast  = (s_beat == last);
    AXI_rresp  = (s_burst == 0 && s_beat == cfg_err) ? 2'b10 : 2'b00;
    if (s_beat < BL) exp_q.push_back(AXI_rdata);
  endtask

  // ---------------- AXI slave model (acts 1 ns after each rising edge) ----------------
  initial begin
    AXI_arready = 1'b0;
    AXI_rvalid  = 1'b0;
    AXI_rlast   = 1'b0;
    AXI_rdata   = '0;
    AXI_rresp   = 2'b00;
    AXI_rid     = 12'd0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        AXI_arready = 1'b0;
        AXI_rvalid  = 1'b0;
        AXI_rlast   = 1'b0;
        s_phase = 0;
        s_burst = 0;
      end else begin
        case (s_phase)
          0: begin
            AXI_rvalid = 1'b0;
            AXI_rlast  = 1'b0;
            AXI_rresp  = 2'b00;
            if (AXI_arvalid) begin
              ar_q.push_back(AXI_araddr);
              ar_cnt++;
              held_addr = AXI_araddr;
              s_wait = (s_burst == 0) ? cfg_ar_delay : 0;
              if (s_wait == 0) begin
                AXI_arready = 1'b1;
                s_phase = 2;
              end else s_phase = 1;
            end
          end
          1: begin
            check("ar_hold_valid", AXI_arvalid, 1);
            check("ar_hold_addr", AXI_araddr, held_addr);
            s_wait--;
            if (s_wait == 0) begin
              AXI_arready = 1'b1;
              s_phase = 2;
            end
          end
          2: begin
            AXI_arready = 1'b0;
            check("ar_to_data_state", fsm_state, 2);
            check("ar_to_data_rready", AXI_rready, 1);
            s_beat = 0;
            present_beat();
            s_phase = 3;
          end
          default: begin
            if (AXI_rlast) begin
              AXI_rvalid = 1'b0;
              AXI_rlast  = 1'b0;
              AXI_rresp  = 2'b00;
              s_burst++;
              s_phase = 0;
            end else begin
              s_beat++;
              present_beat();
            end
          end
        endcase
      end
    end
  end

  // ---------------- stream consumer check (falling edge, before the pop edge) ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && Oen && Ovalid) begin
        if (exp_q.size() == 0) check("sout_unexpected_word", Sout, 32'hFFFF_FFFF);
        else check("sout_data", Sout, exp_q.pop_front());
        n_popped++;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  // ---------------- scenario table ----------------
  typedef struct {
    int          ar_delay;
    int          last_beat;
    int          err_beat;
    int          exp_level;
    logic        exp_len_err;
    logic        exp_resp_err;
    logic [31:0] exp_addr2;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] t1_addrs[5];

  initial begin
    vecs[0] = '{0,  15, -1, 16, 1'b0, 1'b0, 32'h2000_0040};  // clean burst
    vecs[1] = '{10, 15, -1, 16, 1'b0, 1'b0, 32'h2000_0040};  // AR stalled 10 cycles
    vecs[2] = '{0,  10, -1, 11, 1'b1, 1'b0, 32'h2000_0040};  // early RLAST on beat 10
    vecs[3] = '{0,  15,  3, 16, 1'b0, 1'b1, 32'h2000_0040};  // SLVERR on beat 3
    vecs[4] = '{2,  17, -1, 16, 1'b1, 1'b0, 32'h2000_0040};  // overlong: 18 beats
    vecs[5] = '{0,  15, 15, 16, 1'b0, 1'b1, 32'h2000_0040};  // SLVERR on last beat
    t1_addrs[0] = 32'h1000_0000;
    t1_addrs[1] = 32'h1000_0040;
    t1_addrs[2] = 32'h1000_0080;
    t1_addrs[3] = 32'h1000_00C0;
    t1_addrs[4] = 32'h1000_0000;

    // ---- reset state ----
    rst = 1'b1;
    tick(2);
    check_reset_outputs("reset");

    // ---- continuous streaming with ring wrap ----
    base = 32'h1000_0000;
    ring = 32'h100;
    do_reset();
    run = 1'b1;
    Oen = 1'b1;
    for (int i = 0; i < 100 && ar_cnt < 1; i++) tick();
    check("t1_arlen",   AXI_arlen,   4'hF);
    check("t1_arsize",  AXI_arsize,  3'd2);
    check("t1_arburst", AXI_arburst, 2'b01);
    check("t1_arid",    AXI_arid,    12'd0);
    check("t1_arcache", AXI_arcache, 4'b0011);
    check("t1_arlock",  AXI_arlock,  2'b00);
    check("t1_arprot",  AXI_arprot,  3'b000);
    check("t1_arqos",   AXI_arqos,   4'b0000);
    for (int i = 0; i < 2000 && ar_cnt < 5; i++) tick();
    run = 1'b0;
    tick(200);
    check("t1_ar_count", ar_cnt, 5);
    for (int i = 0; i < 5; i++)
      check("t1_araddr", (i < ar_q.size()) ? ar_q[i] : 32'hDEAD_BEEF, t1_addrs[i]);
    check("t1_words_popped", n_popped, 80);
    check("t1_words_left", exp_q.size(), 0);
    check("t1_level_end", level, 0);
    Oen = 1'b0;

    // ---- single-burst scenarios from the table ----
    for (int v = 0; v < 6; v++) begin
      base = 32'h2000_0000;
      ring = 32'h1000;
      do_reset();
      cfg_ar_delay = vecs[v].ar_delay;
      cfg_last     = vecs[v].last_beat;
      cfg_err      = vecs[v].err_beat;
      run = 1'b1;
      for (int i = 0; i < 400 && ar_cnt < 2; i++) tick();
      check("vec_ar1_addr", (ar_q.size() > 0) ? ar_q[0] : 32'hDEAD_BEEF, 32'h2000_0000);
      check("vec_ar2_addr", (ar_q.size() > 1) ? ar_q[1] : 32'hDEAD_BEEF, vecs[v].exp_addr2);
      check("vec_level", level, vecs[v].exp_level);
      check("vec_len_err", len_err, vecs[v].exp_len_err);
      check("vec_resp_err", resp_err, vecs[v].exp_resp_err);
      run = 1'b0;
      tick(40);
    end

    // ---- backpressure: FIFO space reservation ----
    base = 32'h1000_0000;
    ring = 32'h100;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 500 && level != 7'd64; i++) tick();
    tick(30);
    check("t2_full_ar_count", ar_cnt, 4);
    check("t2_full_level", level, 64);
    Oen = 1'b1;
    tick();
    Oen = 1'b0;
    check("t2_one_pop_level", level, 63);
    tick(20);
    check("t2_no_ar_at_63", ar_cnt, 4);
    Oen = 1'b1;
    tick(15);
    Oen = 1'b0;
    check("t2_level_48", level, 48);
    for (int i = 0; i < 10 && ar_cnt < 5; i++) tick();
    check("t2_ar_after_space", ar_cnt, 5);
    check("t2_ar5_addr", (ar_q.size() > 4) ? ar_q[4] : 32'hDEAD_BEEF, 32'h1000_0000);
    run = 1'b0;
    tick(40);

    // ---- run dropped mid-burst, then restart flush ----
    base = 32'h3000_0000;
    ring = 32'h200;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 200 && !(s_phase == 3 && s_beat == 5); i++) tick();
    run = 1'b0;
    tick(60);
    check("t5_ar_count", ar_cnt, 1);
    check("t5_level_kept", level, 16);
    check("t5_state_idle", fsm_state, 0);
    exp_q.delete();
    run = 1'b1;
    for (int i = 0; i < 50 && ar_cnt < 2; i++) tick();
    check("t5_restart_addr", (ar_q.size() > 1) ? ar_q[1] : 32'hDEAD_BEEF, 32'h3000_0000);
    check("t5_flushed_level", level, 0);
    check("t5_flushed_ovalid", Ovalid, 0);
    run = 1'b0;
    tick(40);

    // ---- underrun, then asynchronous reset mid-burst ----
    base = 32'h4000_0000;
    ring = 32'h100;
    do_reset();
    Oen = 1'b1;
    tick();
    Oen = 1'b0;
    tick();
    check("t6_underrun", underrun, 1);
    check("t6_underrun_level", level, 0);
    run = 1'b1;
    for (int i = 0; i < 200 && !(s_phase == 3 && s_beat == 4); i++) tick();
    check("t6_mid_burst_rready", AXI_rready, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_ring_reader.md
Name: axi_ring_reader

Overview:
- AXI3 read-only master that fetches a circular buffer in DDR in fixed-length INCR bursts.
- Fetched words go into an internal first-word-fall-through FIFO, drained by a stream consumer via Oen.
- Parametrised successor of the fixed 32-bit, 16-beat stream/AXI bridge: width, burst length and FIFO depth are generic.
- Adds ring-address wrap, space-reserved burst issue, response/length error flags, and restart/flush.

Parameters:
DATA_W, 32, AXI/stream data width; 32 or 64.
BURST_LEN, 16, beats per burst; 2..16 (AXI3 limit).
FIFO_DEPTH, 64, FIFO words; power of 2, >= 2*BURST_LEN.
AXI_ID, 0, constant 12-bit ARID value.

Ports:
AXI_clk  in  1  single clock for all logic.
rst  in  1  asynchronous active-high reset.
run  in  1  level; high = fetch continuously.
base_addr  in  32  ring start; aligned to burst bytes.
ring_bytes  in  32  ring size; nonzero multiple of burst bytes.
Sout  out  DATA_W  FIFO head word.
Ovalid  out  1  FIFO non-empty.
Oen  in  1  pop strobe.
level  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
resp_err  out  1  sticky: RRESP != OKAY seen.
len_err  out  1  sticky: RLAST position mismatch.
underrun  out  1  sticky: Oen while Ovalid=0.
AXI_araddr/arvalid/arready/arlen/arsize/arburst/arid/arcache/arlock/arprot/arqos  AXI3 AR channel (out except arready).
AXI_rdata/rid/rresp/rlast/rvalid/rready  AXI3 R channel (in except rready).

Behaviour:
- Reset values: all outputs 0 (arvalid, rready, araddr, Ovalid, level, sticky flags); state IDLE; internal address = 0.
- Static AR fields:
  - arlen = BURST_LEN-1; arsize = log2(DATA_W/8); arburst = 01 (INCR).
  - arid = AXI_ID; arcache = 0011; arlock = 0; arprot = 0; arqos = 0.
- BB = BURST_LEN*DATA_W/8 (burst bytes).
- States: IDLE, ADDR, DATA. At most one burst outstanding.
- Restart:
  - A rising edge of run (registered compare) sets restart_pend.
  - In IDLE with restart_pend: addr<=base_addr, FIFO flushed (level=0, Ovalid=0), flags unchanged, restart_pend cleared.
  - A rising edge during ADDR/DATA is deferred until IDLE.
- IDLE->ADDR: run=1, no restart_pend, and level + BURST_LEN <= FIFO_DEPTH (space reserved). arvalid=1 next cycle with araddr=addr.
- ADDR: hold arvalid and araddr stable until arready; on handshake arvalid<=0, beat_cnt<=0, rready<=1, ->DATA.
- DATA:
  - Each rvalid&rready beat is written to the FIFO; beat_cnt++.
  - rresp != 00 sets resp_err; the data is still stored.
  - On a beat with rlast=1: rready<=0, addr <= (addr+BB >= base_addr+ring_bytes) ? base_addr : addr+BB, ->IDLE.
  - len_err is set if rlast=1 with beat_cnt != BURST_LEN-1, or beat_cnt == BURST_LEN-1 with rlast=0.
  - In the overlong case, rready stays 1 until rlast; extra beats are discarded once BURST_LEN beats are stored.
- run falling mid-burst: the burst completes normally and its data is kept, then IDLE; no new AR.
- FIFO (FWFT):
  - Sout = head word whenever Ovalid=1; Sout is undefined when Ovalid=0.
  - Pop occurs on Oen&Ovalid.
  - A simultaneous push and pop leaves level unchanged.
  - Oen&!Ovalid sets underrun; there is no pop.
  - Overflow is impossible by reservation.
- Latency: a word written on R beat at cycle t is visible on Sout/Ovalid at t+1.
- Sticky flags clear only on rst.

Test Plan:
1. DATA_W=32, BURST_LEN=16, base=0x1000_0000, ring=0x100, run=1, Oen=1 always, slave returns incrementing data -> AR addresses 0x1000_0000, 0x40, 0x80, 0xC0, then 0x1000_0000; arlen=0xF, arsize=2; Sout sequence matches slave data with no gaps or duplicates.
2. Oen=0, FIFO_DEPTH=64 -> exactly 4 bursts issued, level=64, no 5th AR. One Oen pulse -> level=63, still no AR. After 16 pops, level=48 -> next AR issued.
3. arready held low 10 cycles -> arvalid and araddr stable throughout; handshake on cycle 11 -> DATA.
4. Slave asserts rlast on beat 10 -> len_err=1, 11 words stored, next AR = addr+0x40. Separate run: RRESP=10 on beat 3 -> resp_err=1, all 16 words stored.
5. run deasserted during beat 5 -> remaining 11 beats accepted, no further AR. run reasserted -> FIFO flushed (level=0), next araddr=base.
6. Oen pulsed with FIFO empty -> underrun=1, level stays 0. rst asserted mid-burst -> all outputs 0 immediately (async), state IDLE.
